// File: rtl/ahb_lite_mem_slave_pkg.sv
// Shared definitions for the AHB-Lite memory slave.
//   htrans_t : HTRANS transfer type codes
//   hsize_t  : HSIZE transfer size codes (only byte/halfword/word are legal)
//   hresp_t  : HRESP response codes
//   state_t  : data-phase FSM states of the slave
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'b000,
    SIZE_HALF = 3'b001,
    SIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_lite_mem_slave_lane_decode.sv
// Combinational byte-lane decoder for little-endian AHB-Lite transfers.
//   size    : HSIZE of the transfer
//   addr_lo : HADDR[1:0]
//   strb    : byte-lane strobes (bit n = byte lane n = HWDATA[8n+7:8n])
//   illegal : size not byte/halfword/word, or address not aligned to size
module ahb_lane_decode
  import ahb_lite_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       illegal
);

  always_comb begin
    strb    = '0;
    illegal = 1'b0;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: begin
        strb    = addr_lo[1] ? 4'b1100 : 4'b0011;
        illegal = addr_lo[0];
      end
      SIZE_WORD: begin
        strb    = '1;
        illegal = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-organised memory slave with programmable wait states and
// the two-cycle ERROR response for illegal transfers.
// Parameters: ADDR_W (HADDR width), DEPTH (32-bit words), WAIT_STATES (0..15,
// wait cycles inserted in every OKAY data phase).
// Ports:
//   HCLK, HRESETn            : clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HREADY    : address-phase inputs
//   HWDATA                   : write data, sampled in the completing data cycle
//   HREADYOUT, HRESP, HRDATA : data-phase response
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned BYTES     = 4 * DEPTH;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t           state, state_next;
  logic [3:0]       wait_cnt, wait_cnt_next;
  logic [IDX_W-1:0] d_idx;
  logic             d_write;
  logic [3:0]       d_strb;
  logic [31:0]      mem [DEPTH];

  htrans_t    trans;
  logic       accept;
  logic       take;
  logic [3:0] strb;
  logic       lane_bad;
  logic       addr_bad;
  logic       illegal;

  assign trans    = htrans_t'(HTRANS);
  assign accept   = HSEL && HREADY && (trans == TRANS_NONSEQ || trans == TRANS_SEQ);
  assign addr_bad = 32'(HADDR) >= BYTES;
  assign illegal  = lane_bad || addr_bad;

  ahb_lane_decode u_lane_decode (
    .size    (HSIZE),
    .addr_lo (HADDR[1:0]),
    .strb    (strb),
    .illegal (lane_bad)
  );

  // A new address phase is only taken in states that drive HREADYOUT high,
  // so a misbehaving HREADY during our own stall cannot corrupt the data phase.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    HREADYOUT     = 1'b1;
    HRESP         = RESP_OKAY;
    take          = 1'b0;
    case (state)
      ST_IDLE: take = accept;
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == '0) state_next = ST_DATA;
        else                wait_cnt_next = wait_cnt - 4'd1;
      end
      ST_DATA: begin
        take       = accept;
        state_next = ST_IDLE;
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = RESP_ERROR;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP      = RESP_ERROR;
        take       = accept;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (take) begin
      if (illegal) begin
        state_next = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_next    = ST_WAIT;
        wait_cnt_next = WAIT_LOAD;
      end else begin
        state_next = ST_DATA;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      d_idx    <= '0;
      d_write  <= 1'b0;
      d_strb   <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (take && !illegal) begin
        d_idx   <= HADDR[IDX_W+1:2];
        d_write <= HWRITE;
        d_strb  <= strb;
      end
    end
  end

  // Storage is deliberately not reset; a write only lands in the DATA cycle,
  // which reset forces the FSM out of.
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && d_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (d_strb[i]) mem[d_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Combinational read so a read directly after a write to the same word
  // sees the value committed at the end of the write's data cycle.
  assign HRDATA = (state == ST_DATA && !d_write) ? mem[d_idx] : '0;

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
AHB-Lite word-addressed memory slave. It is the downstream consumer of the bus master's NONSEQ/IDLE transfers on the shared AHB-Lite bus, and the target of those transfers in block-level benches.
- Supports byte, halfword and word accesses.
- Inserts a programmable number of wait states.
- Returns the two-cycle ERROR response for illegal transfers.

Parameters:
ADDR_W, 12, width of HADDR (byte address) decoded by the slave
DEPTH, 1024, number of 32-bit words in the array; valid byte addresses are 0 .. 4*DEPTH-1
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15)

Ports:
HCLK       input   1       bus clock; all state changes on the rising edge
HRESETn    input   1       asynchronous, active-low reset
HSEL       input   1       slave select
HADDR      input   ADDR_W  byte address (address phase)
HTRANS     input   2       00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE     input   1       1 = write
HSIZE      input   3       000 byte, 001 halfword, 010 word; any other value is illegal
HWDATA     input   32      write data (data phase)
HREADY     input   1       bus-level ready (previous transfer complete)
HREADYOUT  output  1       slave ready
HRESP      output  1       0 OKAY, 1 ERROR
HRDATA     output  32      read data

Behaviour:
- Reset (HRESETn low, asynchronous):
  - FSM to IDLE; HREADYOUT=1, HRESP=0, HRDATA=0.
  - Pending data phase discarded, so no write occurs.
  - Memory contents are not reset.
- Address phase accept: HSEL & HREADY & HTRANS[1] sampled high at a rising edge.
  - Latch addr, write, size and byte strobes.
  - IDLE or BUSY, or HSEL=0: no transfer; slave stays or returns to IDLE with OKAY and zero wait.
- Illegal transfer (detected at accept):
  - HSIZE > 010;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=0;
  - HADDR >= 4*DEPTH.
- Byte strobes (little-endian):
  - byte: 1<<HADDR[1:0];
  - halfword: 0011 or 1100 by HADDR[1];
  - word: 1111.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Legal accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Legal accept with WAIT_STATES=0 -> DATA.
    - Illegal accept -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes this cycle.
    - Write: commit HWDATA lanes selected by the strobes into mem[addr>>2] at the closing edge.
    - Read: HRDATA = mem[addr>>2], full word; the master selects lanes.
    - Next state: new accept this cycle -> WAIT, DATA or ERR1 as from IDLE; otherwise IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2. WAIT_STATES does not apply.
  - ERR2: HREADYOUT=1, HRESP=1; no write and HRDATA=0.
    - Accept in this cycle is allowed and handled as from IDLE.
    - No accept -> IDLE.
- HRDATA is 0 in every state except DATA-with-read.
- Pipelining: back-to-back transfers with no idle cycle between them.
  - WAIT_STATES=0 sustains one transfer per cycle.
  - Read-after-write to the same word returns the new data, because the write commits before the read's data phase.
- The address phase is ignored while HREADY=0 (another slave, or this one, is stalling).
- HWDATA is sampled only in the completing DATA cycle. Its value during WAIT cycles is don't-care.
- SEQ is treated identically to NONSEQ. HBURST is not used; bursts are decoded as individual single transfers.

Decomposition:
- Package ahb_lite_pkg:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ.
  - HSIZE codes: BYTE, HALF, WORD.
  - HRESP codes: OKAY, ERROR.
  - FSM state enum: IDLE, WAIT, DATA, ERR1, ERR2.
- One sub-module, ahb_lane_decode. It is combinational: HSIZE and HADDR[1:0] in; 4-bit strobe and misalign/illegal-size flag out.
- The top level holds the FSM, the wait counter, the data-phase registers and the memory array.

Test Plan:
- Reset: assert HRESETn=0 mid-WAIT with WAIT_STATES=3 -> HREADYOUT=1, HRESP=0 and HRDATA=0 immediately; the pending write to 0x010 is not performed (read of 0x010 after reset returns its previous value).
- Word write/read, WAIT_STATES=0: write 0x004 <- 0xDEADBEEF, then read 0x004 -> HRDATA=0xDEADBEEF one cycle after the read address phase, HRESP=0, no HREADYOUT low.
- Byte/halfword lanes: word 0x008=0x00000000; byte write 0x00A <- 0x00AB0000; halfword write 0x008 <- 0x00001234 -> read 0x008 returns 0x00AB1234.
- Wait states, WAIT_STATES=2: read 0x004 -> HREADYOUT low exactly 2 cycles, then high with data; back-to-back write 0x00C then read 0x00C -> read returns the written value.
- Errors: word write to 0x002, then a write to 4*DEPTH, then HSIZE=011 -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, and memory is unchanged. A NONSEQ issued in the ERR2 cycle completes normally.
- IDLE/BUSY/HSEL=0 cycles and a transfer presented while HREADY=0 -> no state change, OKAY, memory untouched.
